// File: rtl/bpred_pkg.sv
// Shared types for the branch direction predictor.
// Two-bit counter encodings and the predictor FSM state.
package bpred_pkg;

    localparam logic [1:0] STRONGLY_NT = 2'b00;
    localparam logic [1:0] WEAKLY_NT   = 2'b01;
    localparam logic [1:0] WEAKLY_T    = 2'b10;
    localparam logic [1:0] STRONGLY_T  = 2'b11;

    typedef enum logic {
        INIT,
        RUN
    } fsm_e;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter step.
// Moves toward taken or not-taken, clamping at both ends.
module sat_counter2
    import bpred_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != STRONGLY_T) ctr_o = ctr_i + 2'b01;
        end else begin
            if (ctr_i != STRONGLY_NT) ctr_o = ctr_i - 2'b01;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table
// of 2-bit counters; history is speculative and repaired on mispredict.
module gshare_predictor
    import bpred_pkg::*;
#(
    parameter int         PC_W     = 32,
    parameter int         IDX_W    = 7,
    parameter int         GHR_W    = 4,
    parameter logic [1:0] CTR_INIT = WEAKLY_NT
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             ready,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             rsp_valid,
    output logic             rsp_taken,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [GHR_W-1:0] rsp_ghr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    input  logic [GHR_W-1:0] upd_ghr
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       pht_q [DEPTH];
    fsm_e             state_q;
    logic [IDX_W-1:0] sweep_q;
    logic             ready_q;
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic             rsp_valid_q;
    logic             rsp_taken_q;
    logic [IDX_W-1:0] rsp_idx_q;
    logic [GHR_W-1:0] rsp_ghr_q;

    logic             run;
    logic             do_pred;
    logic             do_upd;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_bit;
    logic [GHR_W:0]   spec_ext;
    logic [GHR_W:0]   rec_ext;
    logic [1:0]       upd_ctr;
    logic [1:0]       upd_ctr_nxt;
    logic             pht_we;
    logic [IDX_W-1:0] pht_waddr;
    logic [1:0]       pht_wdata;
    logic             unused_ok;

    assign run     = (state_q == RUN);
    assign do_pred = run & pred_valid;
    assign do_upd  = run & upd_valid;

    assign pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign pred_bit = pht_q[pred_idx][1];

    // One extra bit on top so the shift also works when GHR_W is 1.
    assign spec_ext = {ghr_q, pred_bit};
    assign rec_ext  = {upd_ghr, upd_taken};

    assign unused_ok = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                         spec_ext[GHR_W], rec_ext[GHR_W]};

    always_comb begin
        ghr_d = ghr_q;
        if (do_pred) ghr_d = spec_ext[GHR_W-1:0];
        if (do_upd && upd_mispredict) ghr_d = rec_ext[GHR_W-1:0];
    end

    assign upd_ctr = pht_q[upd_idx];

    sat_counter2 u_ctr (
        .ctr_i   (upd_ctr),
        .taken_i (upd_taken),
        .ctr_o   (upd_ctr_nxt)
    );

    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = upd_idx;
        pht_wdata = upd_ctr_nxt;
        if (!run) begin
            pht_we    = 1'b1;
            pht_waddr = sweep_q;
            pht_wdata = CTR_INIT;
        end else if (upd_valid) begin
            pht_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && pht_we) pht_q[pht_waddr] <= pht_wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                    sweep_q <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ghr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_taken_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_ghr_q   <= '0;
        end else begin
            ghr_q       <= ghr_d;
            rsp_valid_q <= do_pred;
            if (do_pred) begin
                rsp_taken_q <= pred_bit;
                rsp_idx_q   <= pred_idx;
                rsp_ghr_q   <= ghr_q;
            end
        end
    end

    assign ready     = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_taken = rsp_taken_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_ghr   = rsp_ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with a response scoreboard.
// Expected responses are queued at issue and checked by a monitor.
module tb_gshare_predictor;

    localparam int PC_W  = 32;
    localparam int IDX_W = 4;
    localparam int GHR_W = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             ready;
    logic             pred_valid = 1'b0;
    logic [PC_W-1:0]  pred_pc = '0;
    logic             rsp_valid;
    logic             rsp_taken;
    logic [IDX_W-1:0] rsp_idx;
    logic [GHR_W-1:0] rsp_ghr;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_idx = '0;
    logic             upd_taken = 1'b0;
    logic             upd_mispredict = 1'b0;
    logic [GHR_W-1:0] upd_ghr = '0;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q [$];

    gshare_predictor #(
        .PC_W     (PC_W),
        .IDX_W    (IDX_W),
        .GHR_W    (GHR_W),
        .CTR_INIT (2'b01)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ready          (ready),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .rsp_valid      (rsp_valid),
        .rsp_taken      (rsp_taken),
        .rsp_idx        (rsp_idx),
        .rsp_ghr        (rsp_ghr),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .upd_ghr        (upd_ghr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got idx %0h ghr %0h expected none",
                         rsp_idx, rsp_ghr);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("rsp_taken", int'(rsp_taken), int'(e[8]));
                chk("rsp_idx", int'(rsp_idx), int'(e[7:4]));
                chk("rsp_ghr", int'(rsp_ghr), int'(e[3:0]));
            end
        end
    end

    task automatic cyc(input logic pv, input logic [31:0] pc,
                       input logic uv, input logic [3:0] ui,
                       input logic ut, input logic um,
                       input logic [3:0] ug);
        pred_valid     = pv;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_idx        = ui;
        upd_taken      = ut;
        upd_mispredict = um;
        upd_ghr        = ug;
        @(posedge clk);
        #1;
        pred_valid     = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic predict(input logic [31:0] pc, input logic et,
                           input logic [3:0] ei, input logic [3:0] eg);
        exp_q.push_back({et, ei, eg});
        cyc(1'b1, pc, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic train(input logic [3:0] idx, input logic tk);
        cyc(1'b0, 32'h0, 1'b1, idx, tk, 1'b0, 4'h0);
    endtask

    // Counts ready-low cycles after release, poking inputs that must be ignored.
    task automatic sweep_wait(input string name);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            pred_valid = n[0];
            pred_pc    = 32'h0;
            upd_valid  = 1'b1;
            upd_idx    = 4'h0;
            upd_taken  = 1'b1;
            @(posedge clk);
            #1;
            pred_valid = 1'b0;
            upd_valid  = 1'b0;
            n++;
        end
        chk(name, n, 16);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_taken", int'(rsp_taken), 0);
        chk("reset_rsp_idx", int'(rsp_idx), 0);
        chk("reset_rsp_ghr", int'(rsp_ghr), 0);
        resetn = 1'b1;
        sweep_wait("init_len");
        chk("ready_after_init", int'(ready), 1);

        predict(32'h0, 1'b0, 4'h0, 4'h0);

        train(4'h5, 1'b1);
        train(4'h5, 1'b1);
        train(4'h5, 1'b1);
        train(4'h4, 1'b1);
        train(4'h4, 1'b1);

        predict(32'h14, 1'b1, 4'h5, 4'h0);
        predict(32'h14, 1'b1, 4'h4, 4'h1);
        predict(32'h14, 1'b0, 4'h6, 4'h3);

        for (int i = 0; i < 4; i++) train(4'h3, 1'b0);
        train(4'h3, 1'b1);
        predict(32'h14, 1'b0, 4'h3, 4'h6);
        train(4'h3, 1'b1);
        predict(32'h3C, 1'b1, 4'h3, 4'hC);

        // Mispredict repair while a prediction issues in the same cycle.
        exp_q.push_back({1'b0, 4'h9, 4'h9});
        cyc(1'b1, 32'h0, 1'b1, 4'h7, 1'b0, 1'b1, 4'h5);
        predict(32'h0, 1'b0, 4'hA, 4'hA);

        exp_q.push_back({1'b0, 4'h2, 4'h4});
        cyc(1'b1, 32'h18, 1'b1, 4'h2, 1'b1, 1'b0, 4'h0);
        predict(32'h28, 1'b1, 4'h2, 4'h8);

        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_ready", int'(ready), 0);
        chk("midrun_rsp_valid", int'(rsp_valid), 0);
        resetn = 1'b1;
        sweep_wait("reinit_len");

        for (int i = 0; i < 16; i++) begin
            logic [3:0] ii;
            ii = 4'(i);
            predict(32'(i * 4), 1'b0, ii, 4'h0);
        end

        cyc(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
